// File: rtl/led_indicator_driver_pkg.sv
// Shared types and helpers for the front-panel LED driver.
// Channel state encoding and a counter-width helper that never returns zero.
package led_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ON    = 2'd1,
    S_BLINK = 2'd2
  } led_state_t;

  // $clog2 gives 0 for values of 1, which would produce a zero-width counter.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One effect LED: edge detector, blink sequencer and registered output decode.
// Output lags the FSM state by one cycle; blinking is a direct decode of the state register.
module led_channel
  import led_pkg::*;
#(
  parameter int BLINK_HALF_CYCLES = 2_400_000,
  parameter int BLINK_TOGGLES     = 6
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic en,
  input  logic pwm_on,
  output logic led,
  output logic blinking
);

  localparam int HW = clog2_min1(BLINK_HALF_CYCLES);
  localparam int TW = clog2_min1(BLINK_TOGGLES);
  localparam logic [HW-1:0] HALF_RELOAD = HW'(BLINK_HALF_CYCLES - 1);
  localparam logic [TW-1:0] TOG_RELOAD  = TW'(BLINK_TOGGLES - 1);

  led_state_t     state_q;
  logic           phase_q;
  logic [HW-1:0]  half_cnt_q;
  logic [TW-1:0]  tog_cnt_q;
  logic           prev_en_q;
  logic           led_q;
  logic           edge_d;

  assign edge_d = en ^ prev_en_q;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= S_OFF;
      phase_q    <= 1'b0;
      half_cnt_q <= '0;
      tog_cnt_q  <= '0;
      prev_en_q  <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      prev_en_q <= en;

      // Output decode uses the state held during this cycle, so led trails state by one edge.
      case (state_q)
        S_ON:    led_q <= pwm_on;
        S_BLINK: led_q <= phase_q;
        default: led_q <= 1'b0;
      endcase

      if (edge_d) begin
        state_q    <= S_BLINK;
        phase_q    <= 1'b1;
        half_cnt_q <= HALF_RELOAD;
        tog_cnt_q  <= TOG_RELOAD;
      end else begin
        case (state_q)
          S_BLINK: begin
            if (half_cnt_q != '0) begin
              half_cnt_q <= half_cnt_q - 1'b1;
            end else if (tog_cnt_q != '0) begin
              half_cnt_q <= HALF_RELOAD;
              phase_q    <= ~phase_q;
              tog_cnt_q  <= tog_cnt_q - 1'b1;
            end else begin
              state_q <= en ? S_ON : S_OFF;
              phase_q <= 1'b0;
            end
          end
          S_OFF, S_ON: state_q <= state_q;
          default:     state_q <= S_OFF;
        endcase
      end
    end
  end

  assign led      = led_q;
  assign blinking = (state_q == S_BLINK);

endmodule

// File: rtl/led_indicator_driver.sv
// Front-panel LED driver: per-channel blink/PWM indicators plus a retriggerable clip stretcher.
// All outputs are registered; led and busy share one cycle of lag behind the channel state.
module led_indicator_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS          = 4,
  parameter int PWM_BITS          = 8,
  parameter int BLINK_HALF_CYCLES = 2_400_000,
  parameter int BLINK_TOGGLES     = 6,
  parameter int CLIP_HOLD_CYCLES  = 4_800_000
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] fx_en,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                clip_pulse,
  output logic [NUM_LEDS-1:0] led,
  output logic                clip_led,
  output logic                busy
);

  localparam int CW = clog2_min1(CLIP_HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CLIP_RELOAD = CW'(CLIP_HOLD_CYCLES);

  if (BLINK_TOGGLES < 2 || (BLINK_TOGGLES % 2) != 0) begin : g_bad_toggles
    $error("BLINK_TOGGLES must be even and at least 2");
  end
  if (BLINK_HALF_CYCLES < 1) begin : g_bad_half
    $error("BLINK_HALF_CYCLES must be at least 1");
  end
  if (CLIP_HOLD_CYCLES < 1) begin : g_bad_clip
    $error("CLIP_HOLD_CYCLES must be at least 1");
  end

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] bright_q;
  logic                pwm_on;
  logic [CW-1:0]       clip_cnt_q;
  logic [CW-1:0]       clip_cnt_d;
  logic                clip_led_q;
  logic                busy_q;
  logic [NUM_LEDS-1:0] blinking;

  // Brightness is only taken at the period boundary so a mid-period change cannot glitch a pulse.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      bright_q  <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (&pwm_cnt_q) begin
        bright_q <= brightness;
      end
    end
  end

  assign pwm_on = (pwm_cnt_q < bright_q);

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (clip_pulse) begin
      clip_cnt_d = CLIP_RELOAD;
    end else if (clip_cnt_q != '0) begin
      clip_cnt_d = clip_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clip_cnt_q <= '0;
      clip_led_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
      clip_led_q <= (clip_cnt_d != '0);
      busy_q     <= |blinking;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_channel #(
      .BLINK_HALF_CYCLES (BLINK_HALF_CYCLES),
      .BLINK_TOGGLES     (BLINK_TOGGLES)
    ) u_chan (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .en       (fx_en[i]),
      .pwm_on   (pwm_on),
      .led      (led[i]),
      .blinking (blinking[i])
    );
  end

  assign clip_led = clip_led_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_led_indicator_driver.sv
// Bench for led_indicator_driver: scenario tasks plus randomized traffic against a time-based model.
module tb_led_indicator_driver;

  localparam int N  = 4;
  localparam int PB = 4;
  localparam int H  = 4;
  localparam int T  = 4;
  localparam int CH = 10;
  localparam int PERIOD = 1 << PB;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic [N-1:0]  fx_en;
  logic [PB-1:0] brightness;
  logic          clip_pulse;
  logic [N-1:0]  led;
  logic          clip_led;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Model: a blink is tracked as its age in cycles; the LED phase is (age / H) parity.
  int       m_age[N];
  bit       m_on[N];
  bit       m_prev[N];
  int       m_cnt;
  int       m_bright;
  int       m_last_clip;
  int       cyc = 0;
  logic [N-1:0] m_led;
  logic     m_clip;
  logic     m_busy;

  led_indicator_driver #(
    .NUM_LEDS          (N),
    .PWM_BITS          (PB),
    .BLINK_HALF_CYCLES (H),
    .BLINK_TOGGLES     (T),
    .CLIP_HOLD_CYCLES  (CH)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .fx_en      (fx_en),
    .brightness (brightness),
    .clip_pulse (clip_pulse),
    .led        (led),
    .clip_led   (clip_led),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    bit pwm_on;
    @(posedge sys_clk);
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_age[i] = -1; m_on[i] = 0; m_prev[i] = 0;
      end
      m_cnt = 0; m_bright = 0; m_last_clip = -1000000;
      m_led = '0; m_clip = 1'b0; m_busy = 1'b0;
    end else begin
      pwm_on = (m_cnt < m_bright);
      m_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_age[i] >= 0) begin
          m_led[i] = (((m_age[i] / H) % 2) == 0);
          m_busy = 1'b1;
        end else begin
          m_led[i] = m_on[i] && pwm_on;
        end
      end
      if (clip_pulse) m_last_clip = cyc;
      m_clip = ((cyc - m_last_clip) < CH);
      for (int i = 0; i < N; i++) begin
        if (fx_en[i] != m_prev[i]) begin
          m_age[i] = 0;
        end else if (m_age[i] >= 0) begin
          m_age[i]++;
          if (m_age[i] == T * H) begin
            m_age[i] = -1;
            m_on[i]  = fx_en[i];
          end
        end
        m_prev[i] = fx_en[i];
      end
      if (m_cnt == PERIOD - 1) m_bright = brightness;
      m_cnt = (m_cnt + 1) % PERIOD;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fx_en = '0; brightness = '0; clip_pulse = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) reset = 1'b0;
      step();
      checks++;
      if (led !== '0 || clip_led !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset c=%0d: led=%b clip=%b busy=%b, expected all 0", c, led, clip_led, busy);
      end
    end
  endtask

  task automatic test_blink();
    int busy_cnt = 0;
    int hi_cnt = 0;
    fx_en = 4'b0001; brightness = 4'd8;
    for (int j = 1; j <= 40; j++) begin
      step();
      checks++;
      if (led !== m_led || clip_led !== m_clip || busy !== m_busy) begin
        errors++;
        $display("FAIL blink j=%0d: led=%b clip=%b busy=%b, expected led=%b clip=%b busy=%b", j, led, clip_led, busy, m_led, m_clip, m_busy);
      end
      if (j >= 2 && j <= 17) begin
        checks++;
        if (led[0] !== ((((j - 2) / 4) % 2) == 0)) begin
          errors++;
          $display("FAIL blink_pattern j=%0d: led0=%b expected %b", j, led[0], ((((j - 2) / 4) % 2) == 0));
        end
      end
      if (j <= 20 && busy === 1'b1) busy_cnt++;
      if (j >= 25 && led[0] === 1'b1) hi_cnt++;
    end
    checks++;
    if (busy_cnt != 16) begin
      errors++;
      $display("FAIL blink_busy_len: got %0d cycles, expected 16", busy_cnt);
    end
    checks++;
    if (hi_cnt != 8) begin
      errors++;
      $display("FAIL blink_pwm_duty: got %0d of 16 lit, expected 8", hi_cnt);
    end
  endtask

  task automatic test_restart();
    int busy_cnt = 0;
    int rises = 0;
    logic last_busy = 1'b0;
    fx_en = 4'b0011;
    for (int j = 1; j <= 36; j++) begin
      if (j == 7) fx_en = 4'b0001;
      step();
      checks++;
      if (led !== m_led || busy !== m_busy) begin
        errors++;
        $display("FAIL restart j=%0d: led=%b busy=%b, expected led=%b busy=%b", j, led, busy, m_led, m_busy);
      end
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && last_busy === 1'b0) rises++;
      last_busy = busy;
    end
    checks++;
    if (busy_cnt != 22 || rises != 1) begin
      errors++;
      $display("FAIL restart_busy: got %0d cycles in %0d runs, expected 22 in 1", busy_cnt, rises);
    end
  endtask

  task automatic test_pwm();
    int hi_cnt = 0;
    int zero_bad = 0;
    int waited = 0;
    brightness = 4'd4;
    for (int j = 0; j < 20; j++) step();
    while (m_cnt != 6 && waited < 32) begin
      step();
      waited++;
    end
    checks++;
    if (m_cnt != 6) begin
      errors++;
      $display("FAIL pwm_align: pwm phase not reached in %0d cycles", waited);
    end
    brightness = 4'd12;
    for (int j = 1; j <= 40; j++) begin
      step();
      checks++;
      if (led !== m_led || busy !== m_busy) begin
        errors++;
        $display("FAIL pwm_step j=%0d: led=%b busy=%b, expected led=%b busy=%b", j, led, busy, m_led, m_busy);
      end
      if (j > 24 && led[0] === 1'b1) hi_cnt++;
    end
    checks++;
    if (hi_cnt != 12) begin
      errors++;
      $display("FAIL pwm_duty12: got %0d of 16 lit, expected 12", hi_cnt);
    end
    brightness = 4'd0;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j > 24 && led[0] !== 1'b0) zero_bad++;
    end
    checks++;
    if (zero_bad != 0) begin
      errors++;
      $display("FAIL pwm_zero: led0 lit %0d times, expected 0", zero_bad);
    end
  endtask

  task automatic test_clip();
    for (int c = 0; c < 25; c++) begin
      clip_pulse = (c == 0 || c == 7);
      step();
      checks++;
      if (clip_led !== ((c + 1) <= 17) || clip_led !== m_clip) begin
        errors++;
        $display("FAIL clip cycle=%0d: clip_led=%b expected %b", c + 1, clip_led, ((c + 1) <= 17));
      end
    end
    clip_pulse = 1'b0;
  endtask

  task automatic test_reset_mid();
    fx_en = 4'b0101; clip_pulse = 1'b1; brightness = 4'd9;
    step();
    clip_pulse = 1'b0;
    for (int j = 0; j < 5; j++) step();
    reset = 1'b1; fx_en = 4'b1111;
    step();
    checks++;
    if (led !== '0 || clip_led !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: led=%b clip=%b busy=%b, expected all 0", led, clip_led, busy);
    end
    reset = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      checks++;
      if (led !== m_led || busy !== m_busy || !(led === 4'h0 || led === 4'hF)) begin
        errors++;
        $display("FAIL lockstep j=%0d: led=%b busy=%b, expected led=%b busy=%b", j, led, busy, m_led, m_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(7) == 0) fx_en[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(15) == 0) brightness = PB'($urandom);
      clip_pulse = ($urandom_range(19) == 0);
      reset = ($urandom_range(199) == 0);
      step();
      checks++;
      if (led !== m_led || clip_led !== m_clip || busy !== m_busy) begin
        errors++;
        $display("FAIL random j=%0d: led=%b clip=%b busy=%b, expected led=%b clip=%b busy=%b", j, led, clip_led, busy, m_led, m_clip, m_busy);
      end
    end
    reset = 1'b0; clip_pulse = 1'b0;
  endtask

  initial begin
    test_reset();
    test_blink();
    test_restart();
    test_pwm();
    test_clip();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
